// File: rtl/axis_sample_packer.sv
// Packs 16-bit AXIS samples (first sample in LSBs) into 192-bit words, 64 words per frame.
// Latency 1 cycle; input stalls only while a word is ready to complete and the output register is held.
module axis_sample_packer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 192,
    parameter int SAMPLE_WIDTH           = 16,
    parameter int WORDS_PER_FRAME        = 64
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_reset,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  err_short,
    output logic                                  err_long,
    output logic [15:0]                           frame_count
);

    localparam int LANES  = C_M00_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam int WORD_W = $clog2(WORDS_PER_FRAME);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_FRAME - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [LANE_W-1:0]                   lane_q, lane_d;
    logic [WORD_W-1:0]                   word_q, word_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   pack_q, pack_d;
    logic                                out_vld_q, out_vld_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   out_dat_q, out_dat_d;
    logic                                out_last_q, out_last_d;
    logic                                err_short_q, err_short_d;
    logic                                err_long_q, err_long_d;
    logic [15:0]                         frame_cnt_q, frame_cnt_d;

    logic                                accept;
    logic                                last_word;
    logic [SAMPLE_WIDTH-1:0]             sample;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   merged;
    logic                                unused_tdata;

    assign sample       = s00_axis_tdata[SAMPLE_WIDTH-1:0];
    assign unused_tdata = ^s00_axis_tdata;

    // A sample that cannot complete a word never needs the output register.
    assign s00_axis_tready = (state_q == DISCARD)
                           | ((lane_q != LAST_LANE) & ~s00_axis_tlast)
                           | ~out_vld_q
                           | m00_axis_tready;
    assign accept    = s00_axis_tvalid & s00_axis_tready;
    assign last_word = (word_q == LAST_WORD);

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        pack_d      = pack_q;
        out_vld_d   = out_vld_q;
        out_dat_d   = out_dat_q;
        out_last_d  = out_last_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Lanes above the current one are always zero in pack_q, so short words come out padded.
        merged = pack_q;
        merged[lane_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample;

        if (out_vld_q && m00_axis_tready) begin
            out_vld_d = 1'b0;
            if (out_last_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        if (accept) begin
            case (state_q)
                COLLECT: begin
                    if ((lane_q == LAST_LANE) || s00_axis_tlast) begin
                        out_vld_d   = 1'b1;
                        out_dat_d   = merged;
                        out_last_d  = last_word || s00_axis_tlast;
                        pack_d      = '0;
                        lane_d      = '0;
                        word_d      = (last_word || s00_axis_tlast) ? '0 : word_q + 1'b1;
                        err_short_d = s00_axis_tlast && !(last_word && (lane_q == LAST_LANE));
                        if (last_word && (lane_q == LAST_LANE) && !s00_axis_tlast) begin
                            err_long_d = 1'b1;
                            state_d    = DISCARD;
                        end
                    end else begin
                        pack_d = merged;
                        lane_d = lane_q + 1'b1;
                    end
                end
                DISCARD: begin
                    if (s00_axis_tlast) begin
                        state_d = COLLECT;
                        lane_d  = '0;
                        word_d  = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q     <= COLLECT;
            lane_q      <= '0;
            word_q      <= '0;
            pack_q      <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_last_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            pack_q      <= pack_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_last_q  <= out_last_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m00_axis_tvalid = out_vld_q;
    assign m00_axis_tdata  = out_dat_q;
    assign m00_axis_tlast  = out_last_q;
    assign m00_axis_tstrb  = '1;
    assign err_short       = err_short_q;
    assign err_long        = err_long_q;
    assign frame_count     = frame_cnt_q;

endmodule
